facto_ctrl: RTL and testbench
=============================

Name: facto_ctrl

Overview:
- Control and register block for FactoCore: computes operand! iteratively.
- Decodes bus writes to the opstart/opclear/intrEn/operand registers and sequences an external 128x64 multiplier through a start/done handshake.
- Holds result_h/result_l, status and interrupt.
- Provides bus read data for all seven registers.

Parameters:
- ADDR_W, 8, bus address width; register index = s_addr[7:3].

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- s_sel  in  1  slave select
- s_wr  in  1  1=write, 0=read
- s_addr  in  8  byte address; index s_addr[7:3]: 0 opstart, 1 opclear, 2 opdone, 3 intrEn, 4 operand, 5 result_h, 6 result_l
- s_din  in  64  write data
- s_dout  out  64  read data
- mul_start  out  1  one-cycle multiply request
- mul_a  out  128  multiplicand (current result)
- mul_b  out  64  multiplier (current count N)
- mul_done  in  1  one-cycle pulse, product valid
- mul_result  in  128  product, mod 2^128
- m_interrupt  out  1  completion interrupt

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (reset_n).
- Reset values (reset_n=0 at a clk edge):
  - state=IDLE; operand, N, intrEn, result_h, result_l = 0; opdone = 0.
  - mul_start=0, m_interrupt=0.
- Write (s_sel & s_wr, sampled at the clk edge):
  - idx 4: operand <= s_din, only in IDLE; ignored otherwise.
  - idx 3: intrEn <= s_din[0], any state.
  - idx 0 with s_din[0]=1, in IDLE: start, clear opdone[0].
  - idx 1 with s_din[0]=1: clear.
  - idx 2, 5, 6: ignored.
- Read: s_dout is combinational when s_sel & ~s_wr.
  - opstart/opclear read 0.
  - opdone = {61'b0, opdone[2:0]}; opdone[0]=done, opdone[1]=busy (state != IDLE), opdone[2] see Optional Feature.
  - intrEn = {63'b0, intrEn}.
  - operand, result_h, result_l as stored.
  - idx 7..31 and non-read cycles return 0.
- FSM states: IDLE, MUL_REQ, MUL_WAIT, ABORT.
  - IDLE + start:
    - operand <= 1: result <= 1, opdone[0] <= 1, stay IDLE, no mul_start.
    - otherwise: result <= 1, N <= operand, go MUL_REQ.
  - MUL_REQ: mul_start=1 for exactly this cycle, mul_a=result, mul_b=N; next state MUL_WAIT.
  - MUL_WAIT: on mul_done, result <= mul_result and N <= N-1.
    - If N==2: opdone[0] <= 1, go IDLE.
    - Else go MUL_REQ.
    - mul_done arrives no earlier than 1 cycle after mul_start.
  - Clear:
    - result <= 0, opdone <= 0.
    - From IDLE or MUL_REQ: go IDLE. A MUL_REQ cycle that is cleared still asserts mul_start.
    - From MUL_WAIT: go ABORT; wait for mul_done, discard its product, then IDLE.
    - Start while in ABORT is ignored.
- Start while busy (any non-IDLE state): ignored; no state change.
- Clear and start in the same cycle cannot occur (single bus); clear has priority over an internal mul_done in the same cycle.
- Result truncates mod 2^128.
- Iteration cost: 1 + multiplier latency cycles. Total = (operand-1) iterations.
- m_interrupt = opdone[0] & intrEn, registered-level output; stays high until clear, next start, or intrEn=0.
- Reset mid-operation: immediately reset values; a later stray mul_done is ignored in IDLE.

Optional Feature:
- Macro FACTO_OVF_EN.
- Defined: at start, opdone[2] <= (operand > 34). 35! exceeds 128 bits. The computation still runs mod 2^128. opdone[2] is cleared by clear or by the next start.
- Undefined: opdone[2] is constant 0; no comparator.

Test Plan:
- Write operand=5, opstart=1; multiplier model latency 3 -> 4 mul_start pulses with mul_b=5,4,3,2; final result_h=0, result_l=0x78; opdone=0x1; busy low after the last mul_done.
- operand=0 then operand=1, start each -> no mul_start; result_l=1, opdone=0x1 one cycle after the write.
- operand=21, intrEn=1, start -> result_h=0x2, result_l=0xC5077D36B8C40000; m_interrupt=1; write intrEn=0 -> m_interrupt=0 next cycle.
- operand=6, start; after the 2nd mul_start write opclear=1 -> state ABORT, the pending mul_done is ignored; result 0, opdone=0, no further mul_start; a new start with operand=3 gives 6.
- While busy: write opstart and operand=9 -> both ignored, operand reads the old value; read idx 7 -> 0; reset_n=0 in MUL_WAIT -> all outputs 0 next cycle.
- FACTO_OVF_EN defined: operand=35 start -> opdone[2]=1 at once and at completion; operand=34 -> opdone[2]=0; undefined -> opdone[2]=0 for 35.

Source files
------------

// File: rtl/facto_ctrl.sv
// rtl/facto_ctrl.sv - FactoCore control/register block: iterative operand! via external multiplier (optional FACTO_OVF_EN)
module facto_ctrl #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              s_sel,
  input  logic              s_wr,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [63:0]       s_din,
  output logic [63:0]       s_dout,
  output logic              mul_start,
  output logic [127:0]      mul_a,
  output logic [63:0]       mul_b,
  input  logic              mul_done,
  input  logic [127:0]      mul_result,
  output logic              m_interrupt
);

  typedef enum logic [1:0] {IDLE, MUL_REQ, MUL_WAIT, ABORT} state_t;

  state_t        state;
  logic [63:0]   operand;
  logic [63:0]   n;
  logic          intr_en;
  logic [127:0]  result;
  logic          done;
  logic          ovf;

  logic          wr;
  logic [4:0]    idx;
  logic          start_req;
  logic          clear_req;
  logic          done_nxt;
  logic          intr_en_nxt;
  logic          unused_addr;

  assign wr          = s_sel & s_wr;
  assign idx         = s_addr[7:3];
  assign start_req   = wr && (idx == 5'd0) && s_din[0];
  assign clear_req   = wr && (idx == 5'd1) && s_din[0];
  assign unused_addr = ^s_addr[2:0];

  assign mul_a = result;
  assign mul_b = n;

  // Next values of done and intrEn, shared by their registers and the interrupt register
  always_comb begin
    done_nxt    = done;
    intr_en_nxt = intr_en;
    if (wr && (idx == 5'd3)) intr_en_nxt = s_din[0];
    if (clear_req)
      done_nxt = 1'b0;
    else if ((state == IDLE) && start_req)
      done_nxt = (operand <= 64'd1);
    else if ((state == MUL_WAIT) && mul_done && (n == 64'd2))
      done_nxt = 1'b1;
  end

`ifdef FACTO_OVF_EN
  // Overflow flag: latched at start when operand! cannot fit in 128 bits
  always_ff @(posedge clk) begin
    if (!reset_n)
      ovf <= 1'b0;
    else if (clear_req)
      ovf <= 1'b0;
    else if ((state == IDLE) && start_req)
      ovf <= (operand > 64'd34);
  end
`else
  assign ovf = 1'b0;
`endif

  // Control FSM: register writes, multiply sequencing, abort handling
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      operand     <= '0;
      n           <= '0;
      intr_en     <= 1'b0;
      result      <= '0;
      done        <= 1'b0;
      mul_start   <= 1'b0;
      m_interrupt <= 1'b0;
    end else begin
      done        <= done_nxt;
      intr_en     <= intr_en_nxt;
      m_interrupt <= done_nxt & intr_en_nxt;
      mul_start   <= 1'b0;
      if (wr && (idx == 5'd4) && (state == IDLE)) operand <= s_din;
      case (state)
        IDLE: begin
          if (clear_req) begin
            result <= '0;
          end else if (start_req) begin
            result <= 128'd1;
            if (operand > 64'd1) begin
              n         <= operand;
              state     <= MUL_REQ;
              mul_start <= 1'b1;
            end
          end
        end
        MUL_REQ: begin
          if (clear_req) begin
            result <= '0;
            state  <= IDLE;
          end else begin
            state <= MUL_WAIT;
          end
        end
        MUL_WAIT: begin
          if (clear_req) begin
            // A product landing in the clear cycle is already discarded, so no abort wait is needed
            result <= '0;
            state  <= mul_done ? IDLE : ABORT;
          end else if (mul_done) begin
            result <= mul_result;
            n      <= n - 64'd1;
            if (n == 64'd2) begin
              state <= IDLE;
            end else begin
              state     <= MUL_REQ;
              mul_start <= 1'b1;
            end
          end
        end
        ABORT: begin
          if (clear_req) result <= '0;
          if (mul_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Register read mux
  always_comb begin
    s_dout = '0;
    if (s_sel && !s_wr) begin
      case (idx)
        5'd2:    s_dout = {61'b0, ovf, (state != IDLE), done};
        5'd3:    s_dout = {63'b0, intr_en};
        5'd4:    s_dout = operand;
        5'd5:    s_dout = result[127:64];
        5'd6:    s_dout = result[63:0];
        default: s_dout = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_facto_ctrl.sv
// tb/tb_facto_ctrl.sv - self-checking bench for facto_ctrl with a latency-configurable multiplier model
module tb_facto_ctrl;

`ifdef FACTO_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         s_sel = 1'b0;
  logic         s_wr = 1'b0;
  logic [7:0]   s_addr = '0;
  logic [63:0]  s_din = '0;
  logic [63:0]  s_dout;
  logic         mul_start;
  logic [127:0] mul_a;
  logic [63:0]  mul_b;
  logic         mul_done = 1'b0;
  logic [127:0] mul_result = '0;
  logic         m_interrupt;

  int vectors = 0;
  int miscompares = 0;

  int           lat = 3;
  int           cnt = 0;
  logic [127:0] pa;
  logic [63:0]  pb;
  logic [63:0]  bq[$];

  facto_ctrl #(.ADDR_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .s_sel(s_sel), .s_wr(s_wr), .s_addr(s_addr),
    .s_din(s_din), .s_dout(s_dout), .mul_start(mul_start), .mul_a(mul_a),
    .mul_b(mul_b), .mul_done(mul_done), .mul_result(mul_result), .m_interrupt(m_interrupt)
  );

  always #5 clk = ~clk;

  // Multiplier model: product of the captured operands, delivered lat cycles after mul_start
  initial begin
    forever begin
      @(posedge clk);
      #2;
      mul_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          mul_done   = 1'b1;
          mul_result = pa * {64'd0, pb};
        end
      end
      if (mul_start === 1'b1) begin
        pa  = mul_a;
        pb  = mul_b;
        cnt = lat;
        bq.push_back(mul_b);
      end
    end
  end

  function automatic logic [127:0] fact(input int k);
    logic [127:0] r;
    r = 128'd1;
    for (int i = 2; i <= k; i++) r = r * 128'(i);
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr_reg(input logic [4:0] ix, input logic [63:0] d);
    s_sel = 1'b1; s_wr = 1'b1; s_addr = {ix, 3'b000}; s_din = d;
    @(posedge clk);
    #1;
    s_sel = 1'b0; s_wr = 1'b0; s_din = '0;
  endtask

  task automatic rd(input logic [4:0] ix, output logic [63:0] d);
    s_sel = 1'b1; s_wr = 1'b0; s_addr = {ix, 3'b000};
    #1;
    d = s_dout;
    s_sel = 1'b0;
  endtask

  task automatic run_op(input logic [63:0] op);
    wr_reg(5'd4, op);
    wr_reg(5'd0, 64'd1);
  endtask

  task automatic wait_idle(input int max);
    logic [63:0] v;
    int k;
    k = 0;
    rd(5'd2, v);
    while (v[1] && k < max) begin
      @(posedge clk);
      #1;
      rd(5'd2, v);
      k++;
    end
    check("busy_timeout", {127'd0, v[1]}, 128'd0);
  endtask

  task automatic wait_pulses(input int num, input int max);
    int k;
    k = 0;
    while (bq.size() < num && k < max) begin
      @(posedge clk);
      #3;
      k++;
    end
    check("pulse_timeout", 128'(bq.size() >= num), 128'd1);
  endtask

  task automatic check_result(input string tag, input int op);
    logic [63:0] h, l;
    logic [127:0] e;
    e = fact(op);
    rd(5'd5, h);
    rd(5'd6, l);
    check(tag, {h, l}, e);
  endtask

  initial begin
    logic [63:0] v;
    int op;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    rd(5'd2, v);  check("rst_opdone", {64'd0, v}, 128'd0);
    rd(5'd4, v);  check("rst_operand", {64'd0, v}, 128'd0);
    rd(5'd6, v);  check("rst_result_l", {64'd0, v}, 128'd0);
    check("rst_mul_start", {127'd0, mul_start}, 128'd0);
    check("rst_intr", {127'd0, m_interrupt}, 128'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // 5! with latency 3
    lat = 3;
    bq.delete();
    run_op(64'd5);
    wait_idle(500);
    check("f5_pulses", 128'(bq.size()), 128'd4);
    for (int i = 0; i < 4 && i < bq.size(); i++) check("f5_mul_b", {64'd0, bq[i]}, 128'(5 - i));
    rd(5'd5, v);  check("f5_result_h", {64'd0, v}, 128'd0);
    rd(5'd6, v);  check("f5_result_l", {64'd0, v}, 128'h78);
    rd(5'd2, v);  check("f5_opdone", {64'd0, v}, 128'd1);

    // operand 0 and 1: immediate completion, no multiply
    for (int k = 0; k < 2; k++) begin
      bq.delete();
      run_op(64'(k));
      rd(5'd2, v);  check("small_opdone", {64'd0, v}, 128'd1);
      rd(5'd6, v);  check("small_result_l", {64'd0, v}, 128'd1);
      check("small_pulses", 128'(bq.size()), 128'd0);
    end

    // 21! with interrupt
    lat = $urandom_range(1, 4);
    wr_reg(5'd3, 64'd1);
    rd(5'd3, v);  check("intr_en_rd", {64'd0, v}, 128'd1);
    run_op(64'd21);
    check("intr_low_busy", {127'd0, m_interrupt}, 128'd0);
    wait_idle(1000);
    rd(5'd5, v);  check("f21_result_h", {64'd0, v}, 128'h2);
    rd(5'd6, v);  check("f21_result_l", {64'd0, v}, 128'hC5077D36B8C40000);
    check("f21_intr", {127'd0, m_interrupt}, 128'd1);
    wr_reg(5'd3, 64'd0);
    check("intr_off", {127'd0, m_interrupt}, 128'd0);

    // Abort during MUL_WAIT, then restart
    lat = 3;
    bq.delete();
    run_op(64'd6);
    wait_pulses(2, 100);
    @(posedge clk);
    #1;
    wr_reg(5'd1, 64'd1);
    rd(5'd2, v);  check("abort_opdone", {64'd0, v}, 128'h2);
    rd(5'd6, v);  check("abort_result", {64'd0, v}, 128'd0);
    wait_idle(100);
    repeat (4) @(posedge clk);
    #1;
    rd(5'd6, v);  check("abort_discard", {64'd0, v}, 128'd0);
    rd(5'd2, v);  check("abort_idle_opdone", {64'd0, v}, 128'd0);
    check("abort_pulses", 128'(bq.size()), 128'd2);
    bq.delete();
    run_op(64'd3);
    wait_idle(100);
    rd(5'd6, v);  check("f3_after_abort", {64'd0, v}, 128'd6);
    check("f3_pulses", 128'(bq.size()), 128'd2);

    // Writes while busy are ignored
    lat = 2;
    bq.delete();
    run_op(64'd7);
    wr_reg(5'd0, 64'd1);
    wr_reg(5'd4, 64'd9);
    rd(5'd4, v);  check("busy_operand", {64'd0, v}, 128'd7);
    rd(5'd7, v);  check("idx7_read", {64'd0, v}, 128'd0);
    check("no_read_dout", {64'd0, s_dout}, 128'd0);
    wait_idle(200);
    check_result("f7_busy", 7);
    check("f7_pulses", 128'(bq.size()), 128'd6);

    // Randomized operands and latencies against the reference factorial
    for (int t = 0; t < 6; t++) begin
      op  = $urandom_range(2, 30);
      lat = $urandom_range(1, 4);
      bq.delete();
      run_op(64'(op));
      wait_idle(1000);
      check_result("rand_result", op);
      check("rand_pulses", 128'(bq.size()), 128'(op - 1));
      if (bq.size() > 0) begin
        check("rand_first_b", {64'd0, bq[0]}, 128'(op));
        check("rand_last_b", {64'd0, bq[bq.size() - 1]}, 128'd2);
      end
    end

    // Reset while waiting on the multiplier; the stray product must be ignored
    lat = 4;
    bq.delete();
    run_op(64'd8);
    wait_pulses(1, 50);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_mul_start", {127'd0, mul_start}, 128'd0);
    check("rst_mid_intr", {127'd0, m_interrupt}, 128'd0);
    check("rst_mid_mul_a", mul_a, 128'd0);
    check("rst_mid_mul_b", {64'd0, mul_b}, 128'd0);
    rd(5'd2, v);  check("rst_mid_opdone", {64'd0, v}, 128'd0);
    reset_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    rd(5'd2, v);  check("stray_opdone", {64'd0, v}, 128'd0);
    rd(5'd6, v);  check("stray_result", {64'd0, v}, 128'd0);
    check("stray_pulses", 128'(bq.size()), 128'd1);

    // Overflow flag
    lat = 1;
    run_op(64'd35);
    rd(5'd2, v);  check("ovf35_start", {64'd0, v}, OVF_EN ? 128'h6 : 128'h2);
    wait_idle(1000);
    rd(5'd2, v);  check("ovf35_done", {64'd0, v}, OVF_EN ? 128'h5 : 128'h1);
    check_result("f35_trunc", 35);
    run_op(64'd34);
    wait_idle(1000);
    rd(5'd2, v);  check("ovf34_done", {64'd0, v}, 128'h1);
    check_result("f34", 34);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
